// File: rtl/apb_master_arbiter_pkg.sv
// apb_master_arbiter_pkg: shared FSM state encoding and default widths for the APB master arbiter
//   IDLE/SETUP/ACCESS : APB phase encoding held in the FSM state register
//   DEF_*             : default parameter values used by the interface, arbiter and top
package apb_master_arbiter_pkg;
    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] SETUP  = 2'b01;
    localparam logic [1:0] ACCESS = 2'b10;
    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 16;
endpackage

// File: rtl/apb_master_arbiter_if.sv
// apb_master_arbiter_if: APB bus between the arbiter (master) and the register/memory slave
//   psel, penable, pwrite, paddr, pwdata : master -> slave
//   pready, prdata                       : slave -> master
interface apb_master_arbiter_if
    import apb_master_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic              pready;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    modport master (output psel, penable, pwrite, paddr, pwdata, input pready, prdata);
    modport slave (input psel, penable, pwrite, paddr, pwdata, output pready, prdata);
endinterface

// File: rtl/apb_master_arbiter_rr_arbiter.sv
// apb_master_arbiter_rr_arbiter: combinational round-robin pick among eligible requesters
//   req_i  : raw requests
//   mask_i : requesters excluded this cycle
//   last_i : index of the previous grant; search starts at last_i+1
//   gnt_o  : one-hot winner, idx_o : binary winner, any_o : some requester is eligible
module apb_master_arbiter_rr_arbiter
    import apb_master_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [NUM_REQ-1:0] mask_i,
    input  logic [IW-1:0]      last_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IW-1:0]      idx_o,
    output logic               any_o
);
    logic [NUM_REQ-1:0] elig;
    logic [IW-1:0]      cand;
    assign elig  = req_i & ~mask_i;
    assign any_o = |elig;
    // Walk from the farthest offset down to last_i+1 so the nearest eligible candidate is written last and wins.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        cand  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IW'((int'(last_i) + k) % NUM_REQ);
            if (elig[cand]) begin
                idx_o = cand;
                gnt_o = NUM_REQ'(1) << cand;
            end
        end
    end
endmodule

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: round-robin APB master sharing one slave port among NUM_REQ requesters
//   clk, rst_n                          : clock, asynchronous active-high reset
//   req_i, req_addr_i, req_write_i,
//   req_wdata_i                         : per-requester command, held until its done pulse
//   done_o, rsp_rdata_o, rsp_err_o      : one-cycle completion with read data / timeout flag
//   apb                                 : APB master port (all outputs registered)
module apb_master_arbiter
    import apb_master_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ-1:0]        req_write_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]        done_o,
    output logic [DATA_W-1:0]         rsp_rdata_o,
    output logic                      rsp_err_o,
    apb_master_arbiter_if.master      apb
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    logic [1:0]         state_q, state_d;
    logic               psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d, err_q, err_d;
    logic [ADDR_W-1:0]  paddr_q, paddr_d, sel_addr;
    logic [DATA_W-1:0]  pwdata_q, pwdata_d, rdata_q, rdata_d, sel_wdata;
    logic [NUM_REQ-1:0] done_q, done_d, gnt_q, gnt_d, arb_gnt;
    logic [IW-1:0]      last_q, last_d, arb_idx;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               arb_any, sel_write, timed_out;
    // A requester whose done is showing still has req high, so it is masked for that one cycle.
    apb_master_arbiter_rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
        .req_i  (req_i),
        .mask_i (done_q),
        .last_i (last_q),
        .gnt_o  (arb_gnt),
        .idx_o  (arb_idx),
        .any_o  (arb_any)
    );
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
                sel_addr  = req_addr_i[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata_i[i*DATA_W +: DATA_W];
                sel_write = req_write_i[i];
            end
        end
    end
    // cnt_q counts completed ACCESS cycles, so it reads TIMEOUT-1 during the TIMEOUT-th one.
    assign timed_out = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));
    always_comb begin
        state_d   = state_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        done_d    = '0;
        if (state_q == IDLE) begin
            if (arb_any) begin
                state_d  = SETUP;
                psel_d   = 1'b1;
                paddr_d  = sel_addr;
                pwdata_d = sel_wdata;
                pwrite_d = sel_write;
                gnt_d    = arb_gnt;
                last_d   = arb_idx;
            end
        end else if (state_q == SETUP) begin
            state_d   = ACCESS;
            penable_d = 1'b1;
            cnt_d     = '0;
        end else if (apb.pready || timed_out) begin
            state_d   = IDLE;
            psel_d    = 1'b0;
            penable_d = 1'b0;
            done_d    = gnt_q;
            err_d     = !apb.pready;
            rdata_d   = (apb.pready && !pwrite_q) ? apb.prdata : '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q   <= IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            done_q    <= '0;
            gnt_q     <= '0;
            last_q    <= IW'(NUM_REQ - 1);
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            done_q    <= done_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
        end
    end
    assign apb.psel    = psel_q;
    assign apb.penable = penable_q;
    assign apb.pwrite  = pwrite_q;
    assign apb.paddr   = paddr_q;
    assign apb.pwdata  = pwdata_q;
    assign done_o      = done_q;
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;
endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: scoreboard bench for the round-robin APB master arbiter
module tb_apb_master_arbiter;
    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int TO = 16;

    typedef struct {
        int          id;
        logic [AW-1:0] addr;
        logic        wr;
        logic [DW-1:0] wdata;
        int          waits;
        logic [DW-1:0] rdata;
        logic        err;
    } xfer_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    req_write = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    done;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;

    apb_master_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    apb_master_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req),
        .req_addr_i  (req_addr),
        .req_write_i (req_write),
        .req_wdata_i (req_wdata),
        .done_o      (done),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .apb         (bus.master)
    );

    always #5 clk = ~clk;

    xfer_t         exp_q[$];
    int            slv_q[$];
    logic [DW-1:0] mem[256];
    logic [DW-1:0] ref_mem[256];
    xfer_t         plan[N][4];
    int            pcnt[N];
    int            m_last = N - 1;
    int            cur_id = 0;
    int            n_chk = 0;
    int            n_fail = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic clear_plan();
        for (int i = 0; i < N; i++) pcnt[i] = 0;
    endtask

    task automatic add(input int id, input int addr, input logic wr, input logic [DW-1:0] wd, input int w);
        xfer_t x;
        x.id = id; x.addr = AW'(addr); x.wr = wr; x.wdata = wd; x.waits = w;
        x.rdata = '0; x.err = 1'b0;
        plan[id][pcnt[id]] = x;
        pcnt[id]++;
    endtask

    // Reference model: serve pending requesters round-robin from the previous grant,
    // each transfer applied to a reference memory in service order.
    task automatic schedule();
        int ptr[N];
        int left;
        int c;
        xfer_t x;
        left = 0;
        for (int i = 0; i < N; i++) begin ptr[i] = 0; left += pcnt[i]; end
        while (left > 0) begin
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                if (ptr[c] < pcnt[c]) begin
                    x = plan[c][ptr[c]];
                    ptr[c]++;
                    left--;
                    m_last = c;
                    if (x.waits >= TO) begin
                        x.err = 1'b1; x.rdata = '0;
                    end else begin
                        x.err = 1'b0;
                        x.rdata = x.wr ? '0 : ref_mem[x.addr];
                        if (x.wr) ref_mem[x.addr] = x.wdata;
                    end
                    exp_q.push_back(x);
                    slv_q.push_back(x.waits);
                    break;
                end
            end
        end
    endtask

    task automatic load(input int i, input xfer_t x);
        req[i] = 1'b1;
        req_write[i] = x.wr;
        req_addr[i*AW +: AW] = x.addr;
        req_wdata[i*DW +: DW] = x.wdata;
    endtask

    task automatic run_batch(input int lat);
        int ptr[N];
        int total, seen, cyc, first;
        total = 0; seen = 0; cyc = 0; first = -1;
        schedule();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            ptr[i] = 0;
            total += pcnt[i];
            if (pcnt[i] > 0) load(i, plan[i][0]);
        end
        while (seen < total && cyc < 64 * total + 100) begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < N; i++) begin
                if (done[i]) begin
                    seen++;
                    if (first < 0) first = cyc;
                    ptr[i]++;
                    if (ptr[i] < pcnt[i]) load(i, plan[i][ptr[i]]);
                    else req[i] = 1'b0;
                end else if (!req[i]) begin
                    req_addr[i*AW +: AW] = AW'($urandom);
                    req_wdata[i*DW +: DW] = $urandom;
                    req_write[i] = 1'($urandom_range(0, 1));
                end
            end
            if (bus.psel && bus.penable) begin
                req_addr[cur_id*AW +: AW] = AW'($urandom);
                req_wdata[cur_id*DW +: DW] = $urandom;
            end
        end
        check("batch_completions", seen, total);
        if (lat > 0) check("first_done_latency", first, lat);
        req = '0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b1;
        exp_q.delete();
        slv_q.delete();
        req = '0;
        m_last = N - 1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
    endtask

    // APB slave: waits per transfer come from slv_q; a wait count >= TO never answers.
    initial begin
        int acc, w;
        acc = 0; w = 0;
        bus.pready = 1'b0;
        bus.prdata = '0;
        forever begin
            @(negedge clk);
            if (bus.psel && bus.penable) begin
                if (acc == 0) w = slv_q.size() > 0 ? slv_q.pop_front() : 0;
                bus.pready = (w < TO) && (acc == w);
                bus.prdata = mem[bus.paddr];
                if (bus.pready && bus.pwrite) mem[bus.paddr] = bus.pwdata;
                acc++;
            end else begin
                acc = 0;
                bus.pready = 1'($urandom_range(0, 1));
                bus.prdata = $urandom;
            end
        end
    end

    // Monitor: protocol and stability checks, scoreboard pop on every done pulse.
    initial begin
        logic [AW+DW:0] snap;
        logic [DW-1:0]  last_rd;
        logic           was_setup;
        int             acc;
        xfer_t          x;
        snap = '0; last_rd = '0; was_setup = 1'b0; acc = 0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                was_setup = 1'b0; acc = 0; last_rd = '0;
            end else begin
                if (was_setup) check("setup_then_access", {bus.psel, bus.penable}, 2'b11);
                was_setup = bus.psel && !bus.penable;
                if (was_setup) begin
                    acc = 0;
                    snap = {bus.paddr, bus.pwrite, bus.pwdata};
                    check("setup_pending", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        x = exp_q[0];
                        cur_id = x.id;
                        check("setup_paddr", bus.paddr, x.addr);
                        check("setup_pwrite", bus.pwrite, x.wr);
                        if (x.wr) check("setup_pwdata", bus.pwdata, x.wdata);
                    end
                end else if (bus.psel && bus.penable) begin
                    acc++;
                    check("access_stable", {bus.paddr, bus.pwrite, bus.pwdata}, snap);
                end
                if (done != '0) begin
                    check("done_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        x = exp_q.pop_front();
                        check("done_onehot", done, 64'(1) << x.id);
                        check("rsp_err", rsp_err, x.err);
                        check("rsp_rdata", rsp_rdata, x.rdata);
                        check("access_cycles", acc, x.err ? TO : x.waits + 1);
                        check("bus_idle_at_done", {bus.psel, bus.penable}, 2'b00);
                    end
                    last_rd = rsp_rdata;
                end else begin
                    check("rdata_hold", rsp_rdata, last_rd);
                end
            end
        end
    end

    initial begin
        int t;
        for (int i = 0; i < 256; i++) begin mem[i] = $urandom; ref_mem[i] = mem[i]; end
        clear_plan();
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_psel", bus.psel, 0);
        check("rst_penable", bus.penable, 0);
        check("rst_pwrite", bus.pwrite, 0);
        check("rst_paddr", bus.paddr, 0);
        check("rst_pwdata", bus.pwdata, 0);
        check("rst_done", done, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_err", rsp_err, 0);

        clear_plan(); add(0, 8'h10, 1'b1, 32'hDEADBEEF, 0); run_batch(3);

        mem[8'h20] = 32'h12345678; ref_mem[8'h20] = 32'h12345678;
        clear_plan(); add(2, 8'h20, 1'b0, '0, 2); run_batch(5);

        do_reset();
        clear_plan();
        for (int i = 0; i < N; i++) add(i, $urandom_range(0, 15), 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3));
        add(0, $urandom_range(0, 15), 1'b0, '0, 1);
        run_batch(0);

        clear_plan();
        add(1, 8'h30, 1'b1, 32'hA5A5_0001, 0);
        add(1, 8'h30, 1'b0, '0, 1);
        add(3, 8'h31, 1'b1, 32'h0BAD_F00D, 0);
        run_batch(0);

        clear_plan(); add(2, 8'h40, 1'b1, 32'hFFFF_0000, TO); run_batch(0);
        clear_plan(); add(2, 8'h40, 1'b0, '0, 1); run_batch(0);

        clear_plan(); add(1, 8'h50, 1'b0, '0, 10);
        schedule();
        @(negedge clk);
        load(1, plan[1][0]);
        t = 0;
        while (!(bus.psel && bus.penable) && t < 20) begin @(negedge clk); t++; end
        check("reach_access", bus.psel && bus.penable, 1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        exp_q.delete();
        slv_q.delete();
        req = '0;
        m_last = N - 1;
        #1;
        check("midrst_psel", bus.psel, 0);
        check("midrst_penable", bus.penable, 0);
        check("midrst_done", done, 0);
        repeat (2) @(negedge clk);
        check("midrst_no_done", done, 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_rdata", rsp_rdata, 0);
        check("midrst_err", rsp_err, 0);
        clear_plan();
        add(1, 8'h51, 1'b0, '0, 0);
        add(2, 8'h52, 1'b1, 32'h1111_2222, 0);
        add(0, 8'h53, 1'b0, '0, 0);
        run_batch(3);

        repeat (30) begin
            clear_plan();
            for (int i = 0; i < N; i++) begin
                for (int j = $urandom_range(0, 2); j > 0; j--)
                    add(i, $urandom_range(0, 15), 1'($urandom_range(0, 1)), $urandom,
                        $urandom_range(0, 9) == 0 ? TO : $urandom_range(0, 3));
            end
            if (pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3] == 0)
                add($urandom_range(0, N - 1), $urandom_range(0, 15), 1'b0, '0, 0);
            run_batch(0);
        end
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
